vdp_color_palette: RTL and testbench



---
 rtl/vdp_palette_pkg.sv | 26 ++
 rtl/vdp_color_palette_if.sv | 23 ++
 rtl/vdp_palette_write_seq.sv | 51 +++++
 rtl/vdp_color_palette.sv | 89 ++++++++
 tb/tb_vdp_color_palette.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vdp_palette_pkg.sv
// Shared constants and types for the VDP colour palette stage: mode code, entry layout,
// power-on palette and the 3-to-5 bit colour expansion.
package vdp_palette_pkg;

  localparam logic [4:0] c_mode_g7 = 5'b111_00;

  localparam logic [0:0] st_wait_rb = 1'b0;
  localparam logic [0:0] st_wait_g  = 1'b1;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } pal_entry_t;

  // Octal digits read directly as R, G, B.
  localparam pal_entry_t c_default_palette [16] = '{
    9'o000, 9'o000, 9'o161, 9'o373, 9'o117, 9'o237, 9'o511, 9'o267,
    9'o711, 9'o733, 9'o661, 9'o664, 9'o141, 9'o625, 9'o555, 9'o777
  };

  function automatic logic [4:0] expand3to5(input logic [2:0] x);
    return {x, x[2:1]};
  endfunction

endpackage

// File: rtl/vdp_color_palette_if.sv
// CPU-side palette write port: index load, byte strobe and status readback.
// palette_wr_valid is a one-cycle byte strobe with no ready: every strobe is consumed that clock.
interface vdp_color_palette_if;
  import vdp_palette_pkg::*;

  logic       palette_index_set;
  logic [3:0] palette_index_in;
  logic       palette_wr_valid;
  logic [7:0] palette_wr_data;
  logic [3:0] palette_index;
  logic [0:0] wr_state;

  modport master (
    output palette_index_set, palette_index_in, palette_wr_valid, palette_wr_data,
    input  palette_index, wr_state
  );

  modport slave (
    input  palette_index_set, palette_index_in, palette_wr_valid, palette_wr_data,
    output palette_index, wr_state
  );

endinterface

// File: rtl/vdp_palette_write_seq.sv
// Two-byte palette write sequencer: byte0 carries R/B, byte1 carries G and commits the entry,
// then the write index advances (wrapping 15 -> 0).
module vdp_palette_write_seq
  import vdp_palette_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       index_set,
  input  logic [3:0] index_in,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic [3:0] index,
  output logic [0:0] state,
  output logic       wr_en,
  output logic [3:0] wr_addr,
  output pal_entry_t wr_entry
);

  logic [2:0] hold_r;
  logic [2:0] hold_b;
  logic       unused_data;

  assign unused_data = ^{wr_data[7], wr_data[3]};

  // An index load restarts the sequence and swallows any byte strobed in the same clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= st_wait_rb;
      index  <= 4'd0;
      hold_r <= 3'd0;
      hold_b <= 3'd0;
    end else if (index_set) begin
      state <= st_wait_rb;
      index <= index_in;
    end else if (wr_valid) begin
      if (state == st_wait_rb) begin
        hold_r <= wr_data[6:4];
        hold_b <= wr_data[2:0];
        state  <= st_wait_g;
      end else begin
        index <= index + 4'd1;
        state <= st_wait_rb;
      end
    end
  end

  assign wr_en    = !reset && !index_set && wr_valid && (state == st_wait_g);
  assign wr_addr  = index;
  assign wr_entry = {hold_r, wr_data[2:0], hold_b};

endmodule

// File: rtl/vdp_color_palette.sv
// Final VDP colour stage: 2-clock pipeline mapping display_color to 5-bit RGB through the
// 16-entry palette, or as direct GRB332 in G7.
module vdp_color_palette
  import vdp_palette_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           display_color,
  input  logic                 display_color_en,
  input  logic [4:0]           reg_screen_mode,
  vdp_color_palette_if.slave   bus,
  output logic                 vdp_en,
  output logic [4:0]           vdp_r,
  output logic [4:0]           vdp_g,
  output logic [4:0]           vdp_b
);

  logic       wr_en;
  logic [3:0] wr_addr;
  pal_entry_t wr_entry;
  logic [3:0] index;
  logic [0:0] state;

  vdp_palette_write_seq u_write_seq (
    .clk       (clk),
    .reset     (reset),
    .index_set (bus.palette_index_set),
    .index_in  (bus.palette_index_in),
    .wr_valid  (bus.palette_wr_valid),
    .wr_data   (bus.palette_wr_data),
    .index     (index),
    .state     (state),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_entry  (wr_entry)
  );

  assign bus.palette_index = index;
  assign bus.wr_state      = state;

  pal_entry_t palette [16];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) palette[i] <= c_default_palette[i];
    end else if (wr_en) begin
      palette[wr_addr] <= wr_entry;
    end
  end

  logic [7:0] s1_color;
  logic       s1_en;
  logic       s1_g7;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_color <= 8'd0;
      s1_en    <= 1'b0;
      s1_g7    <= 1'b0;
    end else begin
      s1_color <= display_color;
      s1_en    <= display_color_en;
      s1_g7    <= (reg_screen_mode == c_mode_g7);
    end
  end

  // The lookup reads the pre-write array, so a same-clock write shows up one pixel later.
  pal_entry_t sel;

  always_comb begin
    sel = palette[s1_color[3:0]];
    if (s1_g7) sel = {s1_color[4:2], s1_color[7:5], s1_color[1:0], s1_color[1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vdp_en <= 1'b0;
      vdp_r  <= 5'd0;
      vdp_g  <= 5'd0;
      vdp_b  <= 5'd0;
    end else begin
      vdp_en <= s1_en;
      vdp_r  <= expand3to5(sel.r);
      vdp_g  <= expand3to5(sel.g);
      vdp_b  <= expand3to5(sel.b);
    end
  end

endmodule

// File: tb/tb_vdp_color_palette.sv
// Directed and randomized bench for vdp_color_palette against a cycle-level behavioural model.
module tb_vdp_color_palette;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] display_color;
  logic       display_color_en;
  logic [4:0] reg_screen_mode;
  logic       vdp_en;
  logic [4:0] vdp_r, vdp_g, vdp_b;

  always #5 clk = ~clk;

  vdp_color_palette_if bus ();

  vdp_color_palette dut (
    .clk              (clk),
    .reset            (reset),
    .display_color    (display_color),
    .display_color_en (display_color_en),
    .reg_screen_mode  (reg_screen_mode),
    .bus              (bus),
    .vdp_en           (vdp_en),
    .vdp_r            (vdp_r),
    .vdp_g            (vdp_g),
    .vdp_b            (vdp_b)
  );

  int checks = 0;
  int failures = 0;

  // Power-on palette, one hex digit per channel in R,G,B order.
  int def_rgb [16] = '{'h000, 'h000, 'h161, 'h373, 'h117, 'h237, 'h511, 'h267,
                       'h711, 'h733, 'h661, 'h664, 'h141, 'h625, 'h555, 'h777};

  int m_r [16];
  int m_g [16];
  int m_b [16];
  int m_idx, m_pr, m_pb, m_s1_c;
  bit m_pend, m_s1_en, m_s1_g7;
  bit e_en, chk_rgb;
  int e_r, e_g, e_b;

  // 3-bit intensity scaled to 0..31 with rounding.
  function automatic int exp5(int x);
    return (x * 31 + 3) / 7;
  endfunction

  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_r[i] = (def_rgb[i] >> 8) & 7;
      m_g[i] = (def_rgb[i] >> 4) & 7;
      m_b[i] = def_rgb[i] & 7;
    end
    m_idx = 0; m_pend = 0; m_pr = 0; m_pb = 0;
    m_s1_c = 0; m_s1_en = 0; m_s1_g7 = 0;
    e_en = 0; e_r = 0; e_g = 0; e_b = 0;
  endtask

  // One clock: predict this edge's outputs, advance the model, then compare.
  task automatic cycle();
    int c, r3, g3, b3, d;
    if (reset) begin
      model_reset();
      chk_rgb = 1;
    end else begin
      c = m_s1_c;
      if (m_s1_g7) begin
        g3 = (c >> 5) & 7;
        r3 = (c >> 2) & 7;
        b3 = ((c & 3) << 1) | ((c >> 1) & 1);
      end else begin
        r3 = m_r[c % 16]; g3 = m_g[c % 16]; b3 = m_b[c % 16];
      end
      e_en = m_s1_en; e_r = exp5(r3); e_g = exp5(g3); e_b = exp5(b3);
      chk_rgb = m_s1_en;
      d = int'(bus.palette_wr_data);
      if (bus.palette_index_set) begin
        m_idx = int'(bus.palette_index_in);
        m_pend = 0;
      end else if (bus.palette_wr_valid) begin
        if (!m_pend) begin
          m_pr = (d >> 4) & 7; m_pb = d & 7; m_pend = 1;
        end else begin
          m_r[m_idx] = m_pr; m_g[m_idx] = d & 7; m_b[m_idx] = m_pb;
          m_idx = (m_idx + 1) % 16; m_pend = 0;
        end
      end
      m_s1_c = int'(display_color);
      m_s1_en = display_color_en;
      m_s1_g7 = (reg_screen_mode == 5'd28);
    end
    @(posedge clk);
    #1;
    check("vdp_en", 16'(vdp_en), 16'(e_en));
    if (chk_rgb) begin
      check("vdp_r", 16'(vdp_r), 16'(e_r));
      check("vdp_g", 16'(vdp_g), 16'(e_g));
      check("vdp_b", 16'(vdp_b), 16'(e_b));
    end
    check("palette_index", 16'(bus.palette_index), 16'(m_idx));
    check("wr_state", 16'(bus.wr_state), 16'(m_pend));
    bus.palette_index_set = 1'b0;
    bus.palette_wr_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic px(logic [7:0] c);
    display_color = c;
    display_color_en = 1'b1;
    cycle();
  endtask

  task automatic wr(logic [7:0] d);
    bus.palette_wr_valid = 1'b1;
    bus.palette_wr_data = d;
    cycle();
  endtask

  task automatic set_idx(logic [3:0] i);
    bus.palette_index_set = 1'b1;
    bus.palette_index_in = i;
    cycle();
  endtask

  task automatic expect_rgb(string tag, logic [4:0] r, logic [4:0] g, logic [4:0] b);
    check({tag, "_en"}, 16'(vdp_en), 16'd1);
    check({tag, "_r"}, 16'(vdp_r), 16'(r));
    check({tag, "_g"}, 16'(vdp_g), 16'(g));
    check({tag, "_b"}, 16'(vdp_b), 16'(b));
  endtask

  initial begin
    reset = 1'b1;
    display_color = 8'd0;
    display_color_en = 1'b0;
    reg_screen_mode = 5'b00011;
    bus.palette_index_set = 1'b0;
    bus.palette_index_in = 4'd0;
    bus.palette_wr_valid = 1'b0;
    bus.palette_wr_data = 8'd0;
    model_reset();
    cycle();
    reset = 1'b1;
    cycle();
    check("rst_en", 16'(vdp_en), 16'd0);
    check("rst_rgb", 16'({vdp_r, vdp_g, vdp_b}), 16'd0);
    check("rst_index", 16'(bus.palette_index), 16'd0);

    // Default palette lookups in a palette mode.
    px(8'h0F);
    px(8'h02);
    expect_rgb("t1_0f", 5'h1F, 5'h1F, 5'h1F);
    px(8'h00);
    expect_rgb("t1_02", 5'h04, 5'h1B, 5'h04);

    // Single entry write.
    set_idx(4'd5);
    wr(8'h70);
    wr(8'h03);
    check("t2_index", 16'(bus.palette_index), 16'd6);
    px(8'h05);
    px(8'h00);
    expect_rgb("t2_e5", 5'h1F, 5'h0D, 5'h00);

    // Two writes across the 15 -> 0 index wrap.
    set_idx(4'd15);
    wr(8'h10);
    wr(8'h05);
    wr(8'h23);
    wr(8'h04);
    check("t3_index", 16'(bus.palette_index), 16'd1);
    px(8'hF0);
    px(8'h0F);
    expect_rgb("t3_e0", 5'h09, 5'h12, 5'h0D);
    px(8'h00);
    expect_rgb("t3_e15", 5'h04, 5'h16, 5'h00);

    // Index load discards a pending byte and a same-clock byte.
    wr(8'h77);
    bus.palette_wr_valid = 1'b1;
    bus.palette_wr_data = 8'h99;
    set_idx(4'd2);
    check("t4_state", 16'(bus.wr_state), 16'd0);
    wr(8'h11);
    wr(8'h02);
    px(8'h02);
    px(8'h00);
    expect_rgb("t4_e2", 5'h04, 5'h09, 5'h04);

    // G7 direct colour, then back to a palette mode mid-stream.
    reg_screen_mode = 5'b11100;
    px(8'hE3);
    px(8'h1C);
    expect_rgb("t5_e3", 5'h00, 5'h1F, 5'h1F);
    reg_screen_mode = 5'b00011;
    px(8'h1C);
    expect_rgb("t5_1c", 5'h1F, 5'h00, 5'h00);
    px(8'h00);
    expect_rgb("t5_pal_c", 5'h04, 5'h12, 5'h04);

    // Write entry 3 in the same clock its lookup happens: old value first, then new.
    display_color = 8'h03;
    display_color_en = 1'b1;
    wr(8'h11);
    wr(8'h02);
    expect_rgb("t6_old", 5'h0D, 5'h1F, 5'h0D);
    cycle();
    expect_rgb("t6_new", 5'h04, 5'h09, 5'h04);

    // Reset in the middle of a write sequence.
    wr(8'h55);
    check("t6_pend", 16'(bus.wr_state), 16'd1);
    reset = 1'b1;
    cycle();
    check("t6_rst_state", 16'(bus.wr_state), 16'd0);
    px(8'h03);
    px(8'h00);
    expect_rgb("t6_default", 5'h0D, 5'h1F, 5'h0D);
    wr(8'h70);
    wr(8'h01);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      reg_screen_mode = ($urandom_range(0, 2) == 0) ? 5'b11100 : 5'($urandom_range(0, 31));
      display_color = 8'($urandom);
      display_color_en = ($urandom_range(0, 3) != 0);
      bus.palette_index_set = ($urandom_range(0, 15) == 0);
      bus.palette_index_in = 4'($urandom);
      bus.palette_wr_valid = ($urandom_range(0, 1) == 0);
      bus.palette_wr_data = 8'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
